// File: rtl/uart_pkg.sv
// uart_pkg: shared UART timing constants and FSM state encodings
package uart_pkg;
   localparam int CLK_FREQ = 50_000_000;
   localparam int BAUD = 115200;
   localparam int DEF_CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam int DATA_BITS = 8;
   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] START = 3'd1;
   localparam logic [2:0] DATA  = 3'd2;
   localparam logic [2:0] STOP1 = 3'd3;
   localparam logic [2:0] STOP2 = 3'd4;
endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period counter, bit_end marks the last cycle of each bit
module uart_baud_gen
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic restart,
   output logic bit_end
);
   logic [15:0] cnt;
   assign bit_end = cnt == 16'(CLKS_PER_BIT - 1);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt <= '0;
      else cnt <= restart || bit_end ? '0 : cnt + 16'd1;
endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8-bit UART transmitter (8N1/8N2, LSB first) with a one-entry holding register
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
   parameter int STOP_BITS = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] data_in,
   input  logic       data_valid,
   output logic       tx_ready,
   output logic       tx,
   output logic       busy,
   output logic [2:0] state
);
   if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
      $error("uart_tx: STOP_BITS must be 1 or 2");
   end
   logic [1:0] rst_sync;
   logic       rst_i;
   logic [7:0] hold;
   logic [7:0] shift;
   logic       hold_full;
   logic [2:0] bit_idx;
   logic       bit_end;
   logic       accept;
   logic       frame_end;
   logic       load;
   // Assertion is immediate; release is retimed to clk.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) rst_sync <= 2'b00;
      else rst_sync <= {rst_sync[0], 1'b1};
   assign rst_i = rst_sync[1];
   assign accept = data_valid && !hold_full;
   assign frame_end = bit_end && (state == STOP2 || (state == STOP1 && STOP_BITS == 1));
   assign load = hold_full && (state == IDLE || frame_end);
   assign tx_ready = !hold_full;
   assign busy = state != IDLE || hold_full;
   uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) baud (
      .clk(clk),
      .rst_n(rst_i),
      .restart(state == IDLE),
      .bit_end(bit_end)
   );
   always_ff @(posedge clk or negedge rst_i)
      if (!rst_i) begin
         state <= IDLE;
         tx <= 1'b1;
         hold <= '0;
         hold_full <= 1'b0;
         shift <= '0;
         bit_idx <= '0;
      end else begin
         if (accept) hold <= data_in;
         hold_full <= accept ? 1'b1 : load ? 1'b0 : hold_full;
         if (load) begin
            shift <= hold;
            tx <= 1'b0;
            state <= START;
         end else if (bit_end) case (state)
            START: begin
               state <= DATA;
               bit_idx <= '0;
               tx <= shift[0];
            end
            DATA: if (bit_idx == 3'(DATA_BITS - 1)) begin
               state <= STOP1;
               tx <= 1'b1;
            end else begin
               bit_idx <= bit_idx + 3'd1;
               tx <= shift[bit_idx + 3'd1];
            end
            STOP1: state <= STOP_BITS == 2 ? STOP2 : IDLE;
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: vector, corner-case and randomized loopback checks for uart_tx
module tb_uart_tx;
   import uart_pkg::*;
   localparam int CPB = 25;
   localparam int FRAME = 11 * CPB;
   typedef struct { logic [7:0] d; logic [10:0] f; } vec_t;
   logic clk = 0, rst_n = 0, data_valid = 0;
   logic [7:0] data_in = '0;
   logic tx_ready, tx, busy;
   logic [2:0] state;
   int checks = 0, passes = 0, cyc = 0, t_start = 0, t_ready = 0, t1 = 0, w = 0, frame_err = 0;
   bit rx_en = 0;
   logic [7:0] rx_byte, lb_b;
   logic [7:0] rx_q[$], exp_q[$];
   logic [7:0] fixed[4] = '{8'h00, 8'hFF, 8'hA5, 8'h5A};
   vec_t vecs[6];
   uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut (
      .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_valid(data_valid),
      .tx_ready(tx_ready), .tx(tx), .busy(busy), .state(state)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   function automatic logic [10:0] frame_of(input logic [7:0] d);
      return {2'b11, d, 1'b0};
   endfunction
   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
   endtask
   task automatic send(input logic [7:0] b);
      int n = 0;
      while (!tx_ready && n < 3 * FRAME) begin
         @(negedge clk);
         n++;
      end
      if (n == 3 * FRAME) check("send_ready", 32'(tx_ready), 1);
      data_in = b;
      data_valid = 1;
      @(posedge clk);
      @(negedge clk);
      data_valid = 0;
   endtask
   task automatic check_frame(input logic [10:0] f, input string nm, input int delay);
      int n = 0, errs = 0;
      while (tx && n < 4 * FRAME) begin
         @(negedge clk);
         n++;
      end
      check({nm, "_delay"}, n, delay);
      t_start = cyc;
      for (int k = 0; k < FRAME; k++) begin
         if (tx !== f[k / CPB] || busy !== 1'b1) errs++;
         @(negedge clk);
      end
      check({nm, "_wave"}, errs, 0);
   endtask
   task automatic idle_check(input string nm);
      int errs = 0;
      for (int k = 0; k < FRAME; k++) begin
         if (tx !== 1'b1 || busy !== 1'b0) errs++;
         @(negedge clk);
      end
      check(nm, errs, 0);
   endtask
   // Behavioural receiver: samples mid-bit after each start-bit fall.
   initial forever begin
      @(negedge clk);
      if (rx_en && !tx) begin
         repeat (CPB / 2) @(negedge clk);
         if (tx) frame_err++;
         for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            rx_byte[i] = tx;
         end
         repeat (CPB) @(negedge clk);
         if (!tx) frame_err++;
         rx_q.push_back(rx_byte);
      end
   end
   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
   initial begin
      vecs[0] = '{8'h55, 11'b11010101010};
      vecs[1] = '{8'h00, 11'b11000000000};
      vecs[2] = '{8'hFF, 11'b11111111110};
      vecs[3] = '{8'h3C, 11'b11001111000};
      vecs[4] = '{8'h81, 11'b11100000010};
      vecs[5] = '{8'hA5, 11'b11101001010};
      repeat (3) @(negedge clk);
      check("rst_tx", 32'(tx), 1);
      check("rst_ready", 32'(tx_ready), 1);
      check("rst_busy", 32'(busy), 0);
      check("rst_state", 32'(state), 32'(IDLE));
      rst_n = 1;
      repeat (3) @(negedge clk);
      check("idle_tx", 32'(tx), 1);
      foreach (vecs[i]) begin
         send(vecs[i].d);
         check_frame(vecs[i].f, "vec", 1);
         check("vec_busy", 32'(busy), 0);
         check("vec_state", 32'(state), 32'(IDLE));
      end
      send(8'h00);
      fork
         begin
            check_frame(frame_of(8'h00), "b2b_a", 1);
            t1 = t_start;
         end
         begin
            repeat (9 * CPB + 3) @(negedge clk);
            send(8'hFF);
            check("b2b_hold", 32'(tx_ready), 0);
            w = 0;
            while (!tx_ready && w < 2 * FRAME) begin
               @(negedge clk);
               w++;
            end
            t_ready = cyc;
         end
      join
      check_frame(frame_of(8'hFF), "b2b_b", 0);
      check("b2b_gap", t_start - t1, FRAME);
      check("b2b_ready", t_ready, t_start);
      send(8'h12);
      fork
         begin
            check_frame(frame_of(8'h12), "ovf_a", 1);
            check_frame(frame_of(8'h34), "ovf_b", 0);
            idle_check("ovf_idle");
         end
         begin
            send(8'h34);
            repeat (5) @(negedge clk);
            check("ovf_full", 32'(tx_ready), 0);
            data_in = 8'hAA;
            data_valid = 1;
            @(negedge clk);
            data_valid = 0;
         end
      join
      send(8'h99);
      fork
         begin
            check_frame(frame_of(8'h99), "col_a", 1);
            check_frame(frame_of(8'h3C), "col_b", 1);
         end
         begin
            w = 0;
            do begin
               @(negedge clk);
               w++;
            end while (tx && w < FRAME);
            repeat (FRAME - 1) @(negedge clk);
            send(8'h3C);
         end
      join
      send(8'hC3);
      send(8'h5A);
      repeat (4 * CPB + CPB / 2 - 2) @(negedge clk);
      check("pre_rst_state", 32'(state), 32'(DATA));
      check("pre_rst_tx", 32'(tx), 0);
      #2 rst_n = 0;
      #1;
      check("mid_rst_tx", 32'(tx), 1);
      check("mid_rst_state", 32'(state), 32'(IDLE));
      check("mid_rst_ready", 32'(tx_ready), 1);
      check("mid_rst_busy", 32'(busy), 0);
      @(negedge clk);
      rst_n = 1;
      repeat (3) @(negedge clk);
      idle_check("rst_lost");
      send(8'h81);
      check_frame(frame_of(8'h81), "rst_after", 1);
      rx_en = 1;
      for (int i = 0; i < 20; i++) begin
         lb_b = i < 4 ? fixed[i] : 8'($urandom);
         send(lb_b);
         exp_q.push_back(lb_b);
         repeat ($urandom_range(0, 2 * CPB)) @(negedge clk);
      end
      w = 0;
      while (rx_q.size() < 20 && w < 4 * FRAME) begin
         @(negedge clk);
         w++;
      end
      check("lb_count", rx_q.size(), 20);
      foreach (exp_q[i]) check("lb_byte", i < rx_q.size() ? 32'(rx_q[i]) : 32'hx, 32'(exp_q[i]));
      check("lb_frame_err", frame_err, 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- 8-bit UART transmitter, 8 data bits, no parity, two stop bits (8N2), LSB first. Default timing is 115200 baud from the 50 MHz system clock.
- Frame format matches uart_rx, so the pair forms the board's serial link.
- Accepts bytes through a valid/ready handshake into a one-entry holding register, so a queued byte is sent back-to-back with no idle gap.
- Sits between the command/response logic and the TX pin.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per bit (50 MHz / 115200).
- STOP_BITS, 2, number of stop bits, 1 or 2. Any other value is a elaboration error.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  asynchronous, active-low reset.
- data_in  in  8  byte to transmit; sampled only on an accept edge.
- data_valid  in  1  data_in valid request.
- tx_ready  out  1  holding register empty; byte accepted when data_valid && tx_ready at a rising clk edge.
- tx  out  1  serial line to pin; registered; idle high.
- busy  out  1  high while a frame is in progress or the holding register is full.
- state  out  3  current FSM state, for debug only.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - tx=1, tx_ready=1, busy=0, state=IDLE.
  - Holding register empty; shift register, bit index and baud counter cleared.
  - A reset mid-frame forces tx=1 immediately and discards both the frame in flight and any held byte.
- Accept:
  - On edge N with data_valid && tx_ready: hold<=data_in, hold_full<=1, tx_ready falls after edge N.
  - data_valid while tx_ready=0 is ignored; hold is unchanged and no error is flagged.
- FSM states (encoding in the package): IDLE=0, START=1, DATA=2, STOP1=3, STOP2=4.
- IDLE, tx=1: if hold_full at an edge, that edge does all of the following:
  - load shift<=hold;
  - clear hold_full;
  - reset the baud counter to 0;
  - tx<=0;
  - state<=START.
  - Accept-to-start-bit latency is therefore 1 cycle (accept at edge N, tx low after edge N+1).
- Baud counter: 16-bit, counts 0..CLKS_PER_BIT-1. bit_end is the cycle the count equals CLKS_PER_BIT-1; the count wraps to 0 there. Every bit lasts exactly CLKS_PER_BIT cycles.
- START, tx=0: at bit_end go to DATA with bit index=0 and tx<=shift[0].
- DATA, tx=shift[bit_idx]: at bit_end:
  - if bit_idx<7, increment bit_idx and drive the next bit;
  - at bit_idx==7, go to STOP1 with tx<=1.
- STOP1, tx=1: at bit_end:
  - STOP_BITS=2: go to STOP2;
  - STOP_BITS=1: take the frame-end action.
- STOP2, tx=1: at bit_end, take the frame-end action.
- Frame end:
  - hold_full sampled at that edge: load the next byte, go to START, tx<=0. No idle cycle; the next start bit begins immediately.
  - Otherwise: go to IDLE.
- Simultaneous accept and frame end: if the accept lands on the same edge as frame end with hold empty, the FSM sees hold_full=0. It goes to IDLE and starts the new frame on the next edge, giving a one-cycle gap. This gap is legal and required (no bypass path).
- Accepts are allowed in any state while tx_ready=1, including during a frame.
- busy = (state!=IDLE) || hold_full. busy must be registered or decoded from registers only.
- Frame length = (1+8+STOP_BITS)*CLKS_PER_BIT cycles; 4774 cycles at the defaults.
- tx is driven only from flops; no combinational glitches on the pin.

Decomposition:
- Package uart_pkg:
  - state encodings (shared with uart_rx debug decoding);
  - CLK_FREQ=50_000_000, BAUD=115200, CLKS_PER_BIT default;
  - DATA_BITS=8.
- Sub-module uart_baud_gen:
  - ports: clk, rst_n, restart in, bit_end out;
  - parameter CLKS_PER_BIT;
  - same generator reusable by uart_rx.

Test Plan:
- Single byte: write 0x55 with the line idle.
  - tx low one cycle after accept for 434 cycles.
  - Then 1,0,1,0,1,0,1,0, each 434 cycles.
  - Then high 868 cycles; busy high for 4774 cycles, then 0.
- Back-to-back: write 0x00, then 0xFF while the first frame is in STOP1.
  - Second start bit begins exactly 4774 cycles after the first.
  - tx_ready low from the second accept until the second frame loads.
- Overflow: with the frame in flight and hold full, pulse data_valid with 0xAA.
  - Ignored; only the two previously queued bytes appear on tx.
- Frame-end collision: accept 0x3C on the exact STOP2 bit_end edge.
  - tx high for exactly one extra cycle, then the 0x3C frame.
- Reset mid-frame: assert rst_n=0 during DATA bit 3.
  - tx=1 asynchronously, state=IDLE, tx_ready=1, held byte lost.
  - After release, the next write of 0x81 transmits cleanly.
- Loopback: tx into uart_rx, send 0x00, 0xFF, 0xA5, 0x5A, plus 16 random bytes.
  - data_out matches each byte with one data_valid pulse per byte; frame_error never asserted.
